bcd_decade_down_counter: RTL and testbench
==========================================

// Module: bcd_decade_down_counter
// PURPOSE
//   Synchronous multi-digit 8421 BCD down counter with parallel load, count enable
//   and terminal-count output for cascading.
//   Countdown counterpart of the decade up counter.
//   Feeds countdown/timer displays and lab blocks that need a decimal preset-and-expire count.
//   Built from one cascaded decade-down stage per digit.
// PARAMETERS
//   DIGITS   2   number of BCD decades; counter width is 4*DIGITS bits, range 0..10^DIGITS-1
// PORTS
//   clk       in   1          rising-edge clock; the only clock
//   rst       in   1          synchronous reset, ACTIVE-LOW; sampled on rising clk
//   en        in   1          count enable; decrement by one when high
//   load      in   1          parallel load strobe; priority over en
//   load_val  in   4*DIGITS   BCD preset value, digit i = load_val[4i+3:4i]
//   q         out  4*DIGITS   current count, BCD, digit 0 = least significant
//   zero      out  1          combinational: q == 0
//   tc        out  1          combinational terminal count: en & ~load & (q == 0)
//   wrap      out  1          registered one-cycle pulse: a decrement occurred from 0
// BEHAVIOUR
//   - Reset (rst==0 at posedge): q <= 0, wrap <= 0; zero=1, tc=en&~load after reset.
//   - Priority per posedge, highest first: reset > load > en > hold.
//   - load: q <= load_val next cycle (latency 1).
//     Any preset digit > 9 (1010..1111) loads as 9; other digits unaffected. wrap <= 0.
//   - en (no load): each digit i decrements when all lower digits are 0 (digit borrow-in).
//     A digit at 0 with borrow-in becomes 9 and generates borrow-out; otherwise it becomes d-1.
//   - All-zero with en: q wraps to all-9s (e.g. DIGITS=2: 00 -> 99); wrap <= 1 for exactly one cycle.
//   - Neither load nor en: q holds; wrap <= 0.
//   - wrap is high only in the cycle after the wrapping edge. Back-to-back wraps are impossible
//     for DIGITS>=1, since 10^DIGITS cycles separate them.
//   - tc is combinational so an upper cascaded counter may use it as its en, with no added latency.
//     tc must not depend on wrap.
//   - Simultaneous load & en: load wins, no decrement, no wrap.
//   - Reset mid-count overrides load/en in the same cycle; next cycle resumes from 0.
//   - Count register only ever holds legal BCD digits 0..9 (invariant; a bench assertion checks it).
// CONFIGURATION
//   HOLD_AT_ZERO_EN  (define to enable)
//     defined:   en at q==0 leaves q at 0 (saturating countdown). wrap is never asserted (tied 0).
//                tc and zero are unchanged. load still works normally from 0.
//     undefined: wrap-around to all-9s as above; wrap pulses.
// STRUCTURE
//   Shared package bcd_pkg:
//     BCD_W = 4; BCD_MAX = 4'd9; BCD_ZERO = 4'd0;
//     function bcd_sat(input [3:0] d) returns 9 if d>9 else d.
//   Sub-module bcd_down_digit (one decade):
//     ports clk, rst, load, load_d[3:0], bin (borrow-in), d[3:0], bout.
//     bout = bin & (d==0).
//     Top generates DIGITS instances; bin[0]=en&~load, bin[i+1]=bout[i].
//   Top owns the wrap register and the HOLD_AT_ZERO_EN gating. The gating suppresses bin[0] when q==0.
// TESTING
//   1 reset: rst=0 one cycle with en=1, load=1, load_val=8'h57 -> q=8'h00, zero=1, wrap=0.
//   2 load/count: load 8'h12 then en=1 for 3 cycles -> q=8'h11,8'h10,8'h09; zero=0 throughout.
//   3 wrap: load 8'h01, en for 2 cycles -> q=8'h00 (tc=1), then 8'h99 with wrap=1 one cycle;
//     with HOLD_AT_ZERO_EN -> q stays 8'h00, wrap=0.
//   4 priority: q=8'h40, load=1, en=1, load_val=8'h3C -> q=8'h39 (digit C clamped to 9), no decrement.
//   5 reset mid-count: counting from 8'h75, assert rst at q=8'h72 -> next q=8'h00; release -> 99, 98...
//   6 cascade/full sweep: DIGITS=3, load 12'h000, en 1000 cycles
//     -> every step decrements by one in decimal, one wrap pulse, all digits <=9 every cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit clamp used by the decade counter slice.
package bcd_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // Illegal preset codes 1010..1111 collapse to 9.
   function automatic logic [3:0] bcd_sat(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down counter: load, borrow-driven decrement, borrow-out.
module bcd_down_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_d,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   always_ff @(posedge clk) begin
      if (!rst)
         d <= BCD_ZERO;
      else if (load)
         d <= bcd_sat(load_d);
      else if (bin)
         d <= (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
   end

   assign bout = bin & (d == BCD_ZERO);

endmodule

// File: rtl/bcd_decade_down_counter.sv
// Multi-digit BCD down counter with load, enable, terminal count and wrap pulse.
// Optional build macro: HOLD_AT_ZERO_EN (saturate at zero instead of wrapping).
module bcd_decade_down_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   q,
   output logic                  zero,
   output logic                  tc,
   output logic                  wrap
);

   logic [DIGITS-1:0] bin;
   logic [DIGITS-1:0] bout;
   logic              cnt_en;

   assign zero = (q == '0);
   assign tc   = en & ~load & zero;

`ifdef HOLD_AT_ZERO_EN
   assign cnt_en = en & ~load & ~zero;
`else
   assign cnt_en = en & ~load;
`endif

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      if (i == 0) begin : g_lsd
         assign bin[i] = cnt_en;
      end else begin : g_up
         assign bin[i] = bout[i-1];
      end
      bcd_down_digit u_dig (
         .clk    (clk),
         .rst    (rst),
         .load   (load),
         .load_d (load_val[BCD_W*i +: BCD_W]),
         .bin    (bin[i]),
         .d      (q[BCD_W*i +: BCD_W]),
         .bout   (bout[i])
      );
   end

   // Borrow out of the top digit means the whole count just passed through zero.
   // With the saturating build cnt_en is gated at zero, so this stays low.
   always_ff @(posedge clk) begin
      if (!rst)
         wrap <= 1'b0;
      else
         wrap <= bout[DIGITS-1];
   end

endmodule

// File: tb/tb_bcd_decade_down_counter.sv
// Self-checking bench: directed steps, random traffic and a 3-digit full sweep vs a decimal model.
module tb_bcd_decade_down_counter;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [7:0]  load_val, q;
   logic        zero, tc, wrap;
   logic        rst3, en3, load3;
   logic [11:0] load_val3, q3;
   logic        zero3, tc3, wrap3;

   int tests = 0, fails = 0;
   int m2 = 0, m3 = 0;
   bit m2_ok = 0;
   int wraps3 = 0;

   always #5 clk = ~clk;

   bcd_decade_down_counter #(.DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
      .q(q), .zero(zero), .tc(tc), .wrap(wrap));

   bcd_decade_down_counter #(.DIGITS(3)) dut3 (
      .clk(clk), .rst(rst3), .en(en3), .load(load3), .load_val(load_val3),
      .q(q3), .zero(zero3), .tc(tc3), .wrap(wrap3));

   function automatic int pow10(int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // Decimal value of a preset, each nibble clamped to 9.
   function automatic int load_int(logic [11:0] lv, int nd);
      int v = 0;
      for (int i = 0; i < nd; i++) begin
         int dg = int'(lv[4*i +: 4]);
         if (dg > 9) dg = 9;
         v = v + dg * pow10(i);
      end
      return v;
   endfunction

   function automatic logic [31:0] to_bcd(int v, int nd);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [31:0] legal(logic [11:0] v);
      for (int i = 0; i < 3; i++) if (v[4*i +: 4] > 4'd9) return 32'd0;
      return 32'd1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: returns next value and expected wrap.
   task automatic model(input int nd, input bit r, input bit l, input bit e,
                        input logic [11:0] lv, inout int v, output bit w);
      w = 0;
      if (!r) v = 0;
      else if (l) v = load_int(lv, nd);
      else if (e) begin
         if (v == 0) begin
`ifndef HOLD_AT_ZERO_EN
            v = pow10(nd) - 1;
            w = 1;
`endif
         end else v = v - 1;
      end
   endtask

   // One clock of the 2-digit DUT; called at posedge+1, returns at next posedge+1.
   task automatic cyc(input bit r, input bit l, input bit e, input logic [7:0] lv);
      bit w;
      rst = r; load = l; en = e; load_val = lv;
      #1;
      if (m2_ok) begin
         chk("zero", 32'(zero), 32'(m2 == 0));
         chk("tc", 32'(tc), 32'(e && !l && m2 == 0));
      end
      @(posedge clk);
      model(2, r, l, e, {4'h0, lv}, m2, w);
      m2_ok = 1;
      #1;
      chk("q", 32'(q), to_bcd(m2, 2));
      chk("wrap", 32'(wrap), 32'(w));
      chk("legal", legal({4'h0, q}), 32'd1);
   endtask

   initial begin
      bit w;
      rst = 0; en = 0; load = 0; load_val = '0;
      rst3 = 0; en3 = 0; load3 = 0; load_val3 = '0;
      @(posedge clk); #1;

      // reset overrides load and en
      cyc(0, 1, 1, 8'h57);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_wrap", 32'(wrap), 32'd0);

      // load then count through a decade borrow
      cyc(1, 1, 0, 8'h12);
      cyc(1, 0, 1, 8'h00); chk("cnt_11", 32'(q), 32'h11);
      cyc(1, 0, 1, 8'h00); chk("cnt_10", 32'(q), 32'h10);
      cyc(1, 0, 1, 8'h00); chk("cnt_09", 32'(q), 32'h09);
      chk("cnt_zero", 32'(zero), 32'd0);

      // wrap (or saturate) at zero
      cyc(1, 1, 0, 8'h01);
      cyc(1, 0, 1, 8'h00); chk("wr_q0", 32'(q), 32'h00);
      rst = 1; load = 0; en = 1; #1;
      chk("wr_tc", 32'(tc), 32'd1);
      cyc(1, 0, 1, 8'h00);
`ifdef HOLD_AT_ZERO_EN
      chk("wr_q", 32'(q), 32'h00);
      chk("wr_pulse", 32'(wrap), 32'd0);
`else
      chk("wr_q", 32'(q), 32'h99);
      chk("wr_pulse", 32'(wrap), 32'd1);
`endif
      cyc(1, 0, 0, 8'h00); chk("wr_gone", 32'(wrap), 32'd0);

      // load beats en, illegal digit clamps
      cyc(1, 1, 0, 8'h40);
      cyc(1, 1, 1, 8'h3C); chk("prio_q", 32'(q), 32'h39);

      // reset mid-count, then resume from zero
      cyc(1, 1, 0, 8'h75);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h00);
      chk("mid_72", 32'(q), 32'h72);
      cyc(0, 0, 1, 8'h00); chk("mid_rst", 32'(q), 32'h00);
      cyc(1, 0, 1, 8'h00);
`ifndef HOLD_AT_ZERO_EN
      chk("mid_99", 32'(q), 32'h99);
      cyc(1, 0, 1, 8'h00); chk("mid_98", 32'(q), 32'h98);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bit r, l, e;
         logic [7:0] lv;
         r  = ($urandom_range(0, 39) != 0);
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         cyc(r, l, e, lv);
      end
      rst = 1; load = 0; en = 0;

      // 3-digit full sweep from 000
      rst3 = 1; load3 = 1; load_val3 = 12'h000; en3 = 0;
      @(posedge clk);
      model(3, 1, 1, 0, 12'h000, m3, w);
      #1;
      chk("sw_load", 32'(q3), to_bcd(m3, 3));
      load3 = 0; en3 = 1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         model(3, 1, 0, 1, 12'h000, m3, w);
         #1;
         chk("sw_q", 32'(q3), to_bcd(m3, 3));
         chk("sw_wrap", 32'(wrap3), 32'(w));
         chk("sw_legal", legal(q3), 32'd1);
         if (wrap3) wraps3++;
      end
`ifdef HOLD_AT_ZERO_EN
      chk("sw_wraps", 32'(wraps3), 32'd0);
`else
      chk("sw_wraps", 32'(wraps3), 32'd1);
`endif
      en3 = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
